// File: rtl/proc_pkg.sv
// proc_pipe shared definitions: opcodes, MUL FSM states, decode helpers.
// Imported by every file of the proc_pipe slice.
package proc_pkg;

  localparam int OPC_W      = 8;
  localparam int OP_REG_BIT = 7;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_READ = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } fsm_t;

  function automatic logic writes_back(input logic [2:0] op);
    return (op != OP_READ) && (op != OP_ILL);
  endfunction

endpackage

// File: rtl/proc_mul_seq.sv
// Shift-add sequential multiplier, one multiplier bit per cycle.
// done is high in the last busy cycle with prod already complete.
module proc_mul_seq
  import proc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   prod
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  fsm_t state, state_nx;

  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_nx;
  logic [DATA_W-1:0]   mplier;
  logic [CW-1:0]       cnt;

  assign acc_nx = acc + (mplier[0] ? mcand : '0);
  assign prod   = acc_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = MUL_BUSY;
      end
      MUL_BUSY: begin
        if (cnt == LAST) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (state == IDLE && start) begin
      mcand  <= {{DATA_W{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
    end else if (state == MUL_BUSY) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/proc_pipe.sv
// Two-stage ALU core: S1 latch, then execute/write-back with DEPTH-word memory.
// Memory commits on the retiring edge, so the next instruction sees it directly.
module proc_pipe
  import proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int IW     = OPC_W + 3 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [IW-1:0]     instr,
  output logic              res_valid,
  output logic [DATA_W:0]   res,
  output logic [ADDR_W-1:0] res_dest,
  output logic              illegal
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rdy_en;
  logic              s1_valid;
  logic [2:0]        s1_op;
  logic              s1_reg;
  logic [ADDR_W-1:0] s1_dest;
  logic [DATA_W-1:0] s1_op1;
  logic [DATA_W-1:0] s1_op2;

  logic [DATA_W-1:0]   opa, opb, rd;
  logic [DATA_W:0]     alu_res;
  logic                alu_ill;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_prod;
  logic                retire, accept;
  logic                unused;

  assign unused = ^{instr[IW-2 -: 4], instr[3*DATA_W-1 -: DATA_W]};

  assign retire      = s1_valid & ((s1_op != OP_MUL) | mul_done);
  assign instr_ready = rdy_en & (~s1_valid | retire);
  assign accept      = instr_valid & instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_reg   <= 1'b0;
      s1_dest  <= '0;
      s1_op1   <= '0;
      s1_op2   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= instr[IW-OPC_W +: 3];
      s1_reg   <= instr[IW-OPC_W+OP_REG_BIT];
      s1_dest  <= instr[2*DATA_W +: ADDR_W];
      s1_op1   <= instr[DATA_W +: DATA_W];
      s1_op2   <= instr[0 +: DATA_W];
    end else if (retire) begin
      s1_valid <= 1'b0;
    end
  end

  assign opa = s1_reg ? mem[s1_op1[ADDR_W-1:0]] : s1_op1;
  assign opb = s1_reg ? mem[s1_op2[ADDR_W-1:0]] : s1_op2;
  assign rd  = mem[s1_op2[ADDR_W-1:0]];

  proc_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (s1_valid && s1_op == OP_MUL),
    .a     (opa),
    .b     (opb),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    unique case (s1_op)
      OP_AND:  alu_res = {1'b0, opa & opb};
      OP_ADD:  alu_res = {1'b0, opa} + {1'b0, opb};
      OP_READ: alu_res = {1'b0, rd};
      OP_SUB:  alu_res = {1'b0, opa} - {1'b0, opb};
      OP_OR:   alu_res = {1'b0, opa | opb};
      OP_XOR:  alu_res = {1'b0, opa ^ opb};
      OP_MUL:  alu_res = {|mul_prod[2*DATA_W-1:DATA_W],
                          mul_prod[DATA_W-1:0]};
      OP_ILL:  alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res       <= '0;
      res_dest  <= '0;
      illegal   <= 1'b0;
    end else begin
      res_valid <= retire;
      illegal   <= retire & alu_ill;
      if (retire) begin
        res      <= alu_res;
        res_dest <= s1_dest;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (retire && writes_back(s1_op)) begin
      mem[s1_dest] <= alu_res[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_proc_pipe.sv
// Directed bench for proc_pipe (DATA_W=8, DEPTH=256).
// Scoreboard queue of hand-computed results checked on the falling edge.
module tb_proc_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        res_valid;
  logic [8:0]  res;
  logic [7:0]  res_dest;
  logic        illegal;

  always #5 clk = ~clk;

  proc_pipe #(.DATA_W(8), .DEPTH(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .res_valid   (res_valid),
    .res         (res),
    .res_dest    (res_dest),
    .illegal     (illegal)
  );

  typedef struct {
    string      tag;
    logic [8:0] r;
    logic [7:0] dest;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   res_cyc = 0;
  int   prev_cyc = 0;
  int   ready_low = 0;
  int   acc_a, acc_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!instr_ready) ready_low++;
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_res_valid", 32'(res_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, "_res"}, 32'(res), 32'(e.r));
        check({e.tag, "_dest"}, 32'(res_dest), 32'(e.dest));
        check({e.tag, "_illegal"}, 32'(illegal), 32'(e.ill));
      end
      prev_cyc = res_cyc;
      res_cyc  = cyc;
    end
  end

  task automatic send(input string tag, input logic [7:0] opc,
                      input logic [7:0] dest, input logic [7:0] op1,
                      input logic [7:0] op2, input logic [8:0] r,
                      input logic ill, input bit push,
                      output int acc_cyc);
    exp_t e;
    acc_cyc     = 0;
    instr       = {opc, dest, op1, op2};
    instr_valid = 1'b1;
    for (int i = 0; i < 40 && !instr_ready; i++) @(negedge clk);
    if (!instr_ready) begin
      check({tag, "_accept_timeout"}, 32'(instr_ready), 1);
      instr_valid = 1'b0;
      return;
    end
    if (push) begin
      e.tag  = tag;
      e.r    = r;
      e.dest = dest;
      e.ill  = ill;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(instr_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res", 32'(res), 0);
    check("rst_dest", 32'(res_dest), 0);
    check("rst_illegal", 32'(illegal), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(instr_ready), 1);

    send("and_imm", 8'h00, 8'd3, 8'd57, 8'd100, 9'h020, 0, 1, acc_a);
    send("add_imm", 8'h01, 8'd4, 8'd255, 8'd255, 9'h1FE, 0, 1, acc_b);
    drain();
    check("b2b_gap", res_cyc - prev_cyc, 1);
    check("add_latency", res_cyc - acc_b, 1);

    send("read3", 8'h02, 8'd5, 8'd57, 8'd3, 9'h020, 0, 1, t);
    send("read4", 8'h02, 8'd6, 8'd57, 8'd4, 9'h0FE, 0, 1, t);
    send("read5", 8'h02, 8'd7, 8'd0, 8'd5, 9'h000, 0, 1, t);
    drain();

    send("add_pre", 8'h01, 8'd4, 8'd1, 8'd1, 9'h002, 0, 1, t);
    drain();
    send("add_w4", 8'h01, 8'd4, 8'd255, 8'd255, 9'h1FE, 0, 1, t);
    send("reg_add", 8'h81, 8'd7, 8'd3, 8'd4, 9'h11E, 0, 1, t);
    send("read7", 8'h02, 8'd9, 8'd0, 8'd7, 9'h01E, 0, 1, t);
    send("reg_xor_self", 8'h85, 8'd3, 8'd3, 8'd4, 9'h0DE, 0, 1, t);
    send("read3_new", 8'h02, 8'd9, 8'd0, 8'd3, 9'h0DE, 0, 1, t);
    send("or_imm", 8'h04, 8'd3, 8'h20, 8'h00, 9'h020, 0, 1, t);
    drain();

    send("mul_15x17", 8'h06, 8'd8, 8'd15, 8'd17, 9'h0FF, 0, 1, acc_a);
    ready_low = 0;
    drain();
    check("mul_latency", res_cyc - acc_a, 9);
    check("mul_ready_low", ready_low, 8);
    send("mul_16x16", 8'h06, 8'd8, 8'd16, 8'd16, 9'h100, 0, 1, t);
    send("read8", 8'h02, 8'd9, 8'd0, 8'd8, 9'h000, 0, 1, t);
    drain();

    send("illegal", 8'h07, 8'd3, 8'hAA, 8'hBB, 9'h000, 1, 1, t);
    send("read3_keep", 8'h02, 8'd12, 8'd0, 8'd3, 9'h020, 0, 1, t);
    send("sub_0m1", 8'h03, 8'd10, 8'd0, 8'd1, 9'h1FF, 0, 1, t);
    send("read10", 8'h02, 8'd13, 8'd0, 8'd10, 9'h0FF, 0, 1, t);
    drain();

    send("mul_abort", 8'h06, 8'd20, 8'd3, 8'd5, 9'h000, 0, 0, t);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_fsm_idle", 32'(dut.u_mul.state), 0);
    check("abort_ready", 32'(instr_ready), 0);
    check("abort_res_valid", 32'(res_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_ready_after", 32'(instr_ready), 1);
    send("read3_clr", 8'h02, 8'd14, 8'd0, 8'd3, 9'h000, 0, 1, t);
    send("read20_clr", 8'h02, 8'd15, 8'd0, 8'd20, 9'h000, 0, 1, t);
    send("add_post", 8'h01, 8'd16, 8'd100, 8'd27, 9'h07F, 0, 1, t);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
